// File: rtl/sdram_init_seq_pkg.sv
// Shared types and constants for the SDRAM power-up initialization sequencer.
package sdram_init_pkg;

    typedef enum logic [2:0] {
        S_WAIT,
        S_PRE,
        S_TRP,
        S_AREF,
        S_TRFC,
        S_MRS,
        S_TMRD,
        S_DONE
    } init_state_t;

    // Command pin encodings, ordered {cs_n, ras_n, cas_n, we_n}
    localparam logic [3:0] CMD_INHIBIT = 4'b1111;
    localparam logic [3:0] CMD_NOP     = 4'b0111;
    localparam logic [3:0] CMD_PRE     = 4'b0010;
    localparam logic [3:0] CMD_AREF    = 4'b0001;
    localparam logic [3:0] CMD_MRS     = 4'b0000;

    // A10 high selects precharge of all banks
    localparam logic [12:0] PRE_ALL_ADDR = 13'h0400;

    // Largest of the timing parameters, used to size the shared delay counter
    function automatic int max_of5(input int a, input int b, input int c,
                                   input int d, input int e);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        if (e > m) m = e;
        return m;
    endfunction

endpackage

// File: rtl/sdram_init_seq_if.sv
// Bundle between the controller and the init sequencer: configuration and
// re-init request in, SDRAM command pins and completion flag out.
interface sdram_init_seq_if;

    logic [12:0] cfg_mode_reg;
    logic        reinit;
    logic        sdr_cke;
    logic        sdr_cs_n;
    logic        sdr_ras_n;
    logic        sdr_cas_n;
    logic        sdr_we_n;
    logic [12:0] sdr_addr;
    logic [1:0]  sdr_ba;
    logic        init_done;

    // Controller side: supplies configuration, observes the pins
    modport master (
        output cfg_mode_reg, reinit,
        input  sdr_cke, sdr_cs_n, sdr_ras_n, sdr_cas_n, sdr_we_n,
               sdr_addr, sdr_ba, init_done
    );

    // Sequencer side: drives the pins
    modport slave (
        input  cfg_mode_reg, reinit,
        output sdr_cke, sdr_cs_n, sdr_ras_n, sdr_cas_n, sdr_we_n,
               sdr_addr, sdr_ba, init_done
    );

endinterface

// File: rtl/sdram_init_seq_delay_cnt.sv
// Loadable down-counter that sticks at zero; one instance times every wait
// interval of the init sequence.
module sdram_delay_cnt #(
    parameter int              WIDTH   = 8,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             zero
);

    // Load has priority; otherwise count down and hold once zero is reached
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            count <= RST_VAL;
        else if (load)
            count <= load_val;
        else if (count != '0)
            count <= count - WIDTH'(1);
    end

    assign zero = (count == '0);

endmodule

// File: rtl/sdram_init_seq.sv
// SDRAM power-up sequencer: NOP wait, precharge-all, N auto-refreshes,
// load-mode-register, then init_done hands the pins to the main controller.
// Pin registers are loaded from the next-state decode, so the pins always
// show the command of the state the FSM is currently in.
module sdram_init_seq
    import sdram_init_pkg::*;
#(
    parameter int T_PWR_CYC = 10000,
    parameter int T_RP      = 2,
    parameter int T_RFC     = 7,
    parameter int N_AREF    = 8,
    parameter int T_MRD     = 2
) (
    input  logic              clk,
    input  logic              rst,
    sdram_init_seq_if.slave   bus
);

    localparam int CNT_W = $clog2(max_of5(T_PWR_CYC, T_RP, T_RFC, N_AREF, T_MRD)) + 1;
    localparam int REF_W = $clog2(N_AREF + 1);

    // The command cycle itself is the first cycle of each interval, so the
    // counter is loaded on entry to the command state with interval-1 and
    // the following wait state runs until it reaches zero. The power-up wait
    // has no command cycle in front of it and therefore starts one higher.
    localparam logic [CNT_W-1:0] PWR_LOAD = CNT_W'(T_PWR_CYC);
    localparam logic [CNT_W-1:0] RP_LOAD  = CNT_W'(T_RP - 1);
    localparam logic [CNT_W-1:0] RFC_LOAD = CNT_W'(T_RFC - 1);
    localparam logic [CNT_W-1:0] MRD_LOAD = CNT_W'(T_MRD - 1);
    localparam logic [REF_W-1:0] N_AREF_V = REF_W'(N_AREF);

    init_state_t      state;
    init_state_t      next_state;
    logic [REF_W-1:0] ref_cnt;
    logic             cnt_load;
    logic [CNT_W-1:0] cnt_load_val;
    logic [CNT_W-1:0] cnt_count;
    logic             cnt_zero;
    logic [3:0]       cmd_d;
    logic [12:0]      addr_d;
    logic             init_done_d;

    sdram_delay_cnt #(
        .WIDTH   (CNT_W),
        .RST_VAL (PWR_LOAD)
    ) u_delay (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .count    (cnt_count),
        .zero     (cnt_zero)
    );

    // State register plus refresh tally, cleared at the start of each sequence
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_WAIT;
            ref_cnt <= '0;
        end else begin
            state <= next_state;
            if (next_state == S_PRE)
                ref_cnt <= '0;
            else if (state == S_AREF)
                ref_cnt <= ref_cnt + REF_W'(1);
        end
    end

    // Sequence progression; every state leaves once its interval has expired
    always_comb begin
        next_state = state;
        case (state)
            S_WAIT: if (cnt_zero) next_state = S_PRE;
            S_PRE:  next_state = cnt_zero ? S_AREF : S_TRP;
            S_TRP:  if (cnt_zero) next_state = S_AREF;
            S_AREF: begin
                if (!cnt_zero)
                    next_state = S_TRFC;
                else if ((ref_cnt + REF_W'(1)) < N_AREF_V)
                    next_state = S_AREF;
                else
                    next_state = S_MRS;
            end
            S_TRFC: if (cnt_zero) next_state = (ref_cnt < N_AREF_V) ? S_AREF : S_MRS;
            S_MRS:  next_state = cnt_zero ? S_DONE : S_TMRD;
            S_TMRD: if (cnt_zero) next_state = S_DONE;
            S_DONE: if (bus.reinit) next_state = S_PRE;
            default: next_state = S_WAIT;
        endcase
    end

    // Pin values and counter reload for the state being entered
    always_comb begin
        cmd_d        = CMD_NOP;
        addr_d       = '0;
        init_done_d  = 1'b0;
        cnt_load     = 1'b0;
        cnt_load_val = '0;
        case (next_state)
            S_PRE: begin
                cmd_d        = CMD_PRE;
                addr_d       = PRE_ALL_ADDR;
                cnt_load     = 1'b1;
                cnt_load_val = RP_LOAD;
            end
            S_AREF: begin
                cmd_d        = CMD_AREF;
                cnt_load     = 1'b1;
                cnt_load_val = RFC_LOAD;
            end
            S_MRS: begin
                cmd_d        = CMD_MRS;
                addr_d       = bus.cfg_mode_reg;
                cnt_load     = 1'b1;
                cnt_load_val = MRD_LOAD;
            end
            S_DONE: init_done_d = 1'b1;
            default: ;
        endcase
    end

    // Registered pins; reset parks the bus in INHIBIT with the clock disabled
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.sdr_cke   <= 1'b0;
            {bus.sdr_cs_n, bus.sdr_ras_n, bus.sdr_cas_n, bus.sdr_we_n} <= CMD_INHIBIT;
            bus.sdr_addr  <= '0;
            bus.sdr_ba    <= '0;
            bus.init_done <= 1'b0;
        end else begin
            bus.sdr_cke   <= 1'b1;
            {bus.sdr_cs_n, bus.sdr_ras_n, bus.sdr_cas_n, bus.sdr_we_n} <= cmd_d;
            bus.sdr_addr  <= addr_d;
            bus.sdr_ba    <= '0;
            bus.init_done <= init_done_d;
        end
    end

endmodule

// File: tb/tb_sdram_init_seq.sv
// Bench for the SDRAM init sequencer: three instances (bench timing, default
// timing, minimum-interval corner) compared cycle by cycle with a schedule
// computed from the command timetable.
module tb_sdram_init_seq;

    typedef struct packed {
        logic        cke;
        logic [3:0]  cmd;
        logic [12:0] addr;
        logic [1:0]  ba;
        logic        done;
    } pins_t;

    localparam logic [3:0] NOP  = 4'b0111;
    localparam logic [3:0] PRE  = 4'b0010;
    localparam logic [3:0] AREF = 4'b0001;
    localparam logic [3:0] MRS  = 4'b0000;

    logic clk = 1'b0;
    logic rst_a, rst_b, rst_c;
    int   vectors     = 0;
    int   miscompares = 0;
    int   aref_seen   = 0;
    int   mrs_seen    = 0;
    int   r_ign;
    int   r_hon;

    sdram_init_seq_if ifa ();
    sdram_init_seq_if ifb ();
    sdram_init_seq_if ifc ();

    pins_t pins_a, pins_b, pins_c;

    assign pins_a = {ifa.sdr_cke, ifa.sdr_cs_n, ifa.sdr_ras_n, ifa.sdr_cas_n,
                     ifa.sdr_we_n, ifa.sdr_addr, ifa.sdr_ba, ifa.init_done};
    assign pins_b = {ifb.sdr_cke, ifb.sdr_cs_n, ifb.sdr_ras_n, ifb.sdr_cas_n,
                     ifb.sdr_we_n, ifb.sdr_addr, ifb.sdr_ba, ifb.init_done};
    assign pins_c = {ifc.sdr_cke, ifc.sdr_cs_n, ifc.sdr_ras_n, ifc.sdr_cas_n,
                     ifc.sdr_we_n, ifc.sdr_addr, ifc.sdr_ba, ifc.init_done};

    sdram_init_seq #(.T_PWR_CYC(20), .T_RP(2), .T_RFC(7), .N_AREF(8), .T_MRD(2))
        dut_a (.clk(clk), .rst(rst_a), .bus(ifa));

    sdram_init_seq #(.T_PWR_CYC(10000), .T_RP(2), .T_RFC(7), .N_AREF(8), .T_MRD(2))
        dut_b (.clk(clk), .rst(rst_b), .bus(ifb));

    sdram_init_seq #(.T_PWR_CYC(20), .T_RP(1), .T_RFC(1), .N_AREF(1), .T_MRD(1))
        dut_c (.clk(clk), .rst(rst_c), .bus(ifc));

    // Free-running clock shared by all three instances
    always #5 clk = ~clk;

    function automatic pins_t reset_pins();
        pins_t p;
        p.cke  = 1'b0;
        p.cmd  = 4'b1111;
        p.addr = '0;
        p.ba   = '0;
        p.done = 1'b0;
        return p;
    endfunction

    // Expected pins at cycle t for a sequence whose precharge lands at pre_at
    function automatic pins_t model(input int t, input int pre_at, input int t_rp,
                                    input int t_rfc, input int n_aref, input int t_mrd,
                                    input logic [12:0] mode, input logic done_before);
        pins_t p;
        int    mrs_at;
        p.cke  = 1'b1;
        p.cmd  = NOP;
        p.addr = '0;
        p.ba   = '0;
        p.done = 1'b0;
        mrs_at = pre_at + t_rp + n_aref * t_rfc;
        if (t < pre_at) begin
            p.done = done_before;
        end else if (t == pre_at) begin
            p.cmd  = PRE;
            p.addr = 13'h0400;
        end else if (t == mrs_at) begin
            p.cmd  = MRS;
            p.addr = mode;
        end else if (t >= mrs_at + t_mrd) begin
            p.done = 1'b1;
        end else if (t >= pre_at + t_rp && t < mrs_at && ((t - pre_at - t_rp) % t_rfc) == 0) begin
            p.cmd = AREF;
        end
        return p;
    endfunction

    task automatic check_output(input string tag, input int cyc, input pins_t obs, input pins_t exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s cycle %0d: observed %h expected %h", tag, cyc, obs, exp);
        end
    endtask

    task automatic check_count(input string tag, input int obs, input int exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic apply_stimulus(input int sel, input logic val);
        case (sel)
            0:       ifa.reinit = val;
            1:       ifb.reinit = val;
            default: ifc.reinit = val;
        endcase
    endtask

    // Step cycles from_t..to_t on one instance, checking each against the
    // timetable; a reinit pulse is raised after the check of cycle reinit_at
    task automatic run_cycles(input int sel, input int from_t, input int to_t,
                              input int pre_at, input logic done_before,
                              input int reinit_at, input string tag);
        pins_t obs;
        pins_t exp;
        for (int t = from_t; t <= to_t; t++) begin
            @(posedge clk);
            @(negedge clk);
            apply_stimulus(sel, 1'b0);
            case (sel)
                0: begin
                    obs = pins_a;
                    exp = model(t, pre_at, 2, 7, 8, 2, ifa.cfg_mode_reg, done_before);
                end
                1: begin
                    obs = pins_b;
                    exp = model(t, pre_at, 2, 7, 8, 2, ifb.cfg_mode_reg, done_before);
                end
                default: begin
                    obs = pins_c;
                    exp = model(t, pre_at, 1, 1, 1, 1, ifc.cfg_mode_reg, done_before);
                end
            endcase
            check_output(tag, t, obs, exp);
            if (obs.cmd === AREF) aref_seen++;
            if (obs.cmd === MRS)  mrs_seen++;
            if (t == reinit_at) apply_stimulus(sel, 1'b1);
        end
    endtask

    initial begin
        rst_a = 1'b1;
        rst_b = 1'b1;
        rst_c = 1'b1;
        ifa.reinit = 1'b0;
        ifb.reinit = 1'b0;
        ifc.reinit = 1'b0;
        ifa.cfg_mode_reg = 13'h0033;
        ifb.cfg_mode_reg = 13'($urandom);
        ifc.cfg_mode_reg = 13'($urandom);

        @(negedge clk);
        check_output("reset_a", -1, pins_a, reset_pins());
        check_output("reset_b", -1, pins_b, reset_pins());
        check_output("reset_c", -1, pins_c, reset_pins());

        $display("[TB] bench timing, plain bring-up then reinit at 100");
        rst_a = 1'b0;
        run_cycles(0, 0, 100, 20, 1'b0, 100, "bringup");
        run_cycles(0, 101, 170, 101, 1'b1, -1, "reinit100");

        $display("[TB] random mode register, random reinit in done");
        ifa.cfg_mode_reg = 13'($urandom);
        r_hon = int'($urandom_range(171, 180));
        run_cycles(0, 171, r_hon, 101, 1'b1, r_hon, "pre_rnd_reinit");
        run_cycles(0, r_hon + 1, r_hon + 66, r_hon + 1, 1'b1, -1, "rnd_reinit");

        $display("[TB] reset during third auto-refresh");
        rst_a = 1'b1;
        @(negedge clk);
        rst_a = 1'b0;
        run_cycles(0, 0, 35, 20, 1'b0, -1, "pre_reset");
        @(posedge clk);
        #2;
        check_output("aref3", 36, pins_a, model(36, 20, 2, 7, 8, 2, ifa.cfg_mode_reg, 1'b0));
        rst_a = 1'b1;
        #1;
        check_output("async_reset", 36, pins_a, reset_pins());
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            @(negedge clk);
            check_output("reset_held", i, pins_a, reset_pins());
        end
        rst_a = 1'b0;

        $display("[TB] reinit pulses mid-sequence are ignored");
        r_ign = int'($urandom_range(31, 79));
        run_cycles(0, 0, 30, 20, 1'b0, 30, "after_reset");
        run_cycles(0, 31, r_ign, 20, 1'b0, r_ign, "ign_reinit30");
        run_cycles(0, r_ign + 1, 90, 20, 1'b0, -1, "ign_reinit_rnd");

        $display("[TB] minimum-interval corner");
        rst_c = 1'b0;
        run_cycles(2, 0, 30, 20, 1'b0, 30, "corner");
        run_cycles(2, 31, 40, 31, 1'b1, -1, "corner_reinit");

        $display("[TB] default timing");
        aref_seen = 0;
        mrs_seen  = 0;
        rst_b = 1'b0;
        run_cycles(1, 0, 10070, 10000, 1'b0, -1, "defaults");
        check_count("default_aref_count", aref_seen, 8);
        check_count("default_mrs_count", mrs_seen, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/sdram_init_seq.md
# sdram_init_seq

Power-up initialization sequencer for the SDRAM controller. After reset it drives the JEDEC bring-up sequence onto the SDRAM command pins: power-up NOP wait, precharge-all, N auto-refreshes, then load-mode-register. It then raises `init_done` so the controller's main command FSM can take over the pins. It sits directly upstream of the controller's command mux; `init_done` is the mux select and the gate for Wishbone traffic.

## Interface
Parameters:
- `T_PWR_CYC`, 10000: NOP cycles after reset before the first precharge (≥1).
- `T_RP`, 2: precharge-to-next-command cycles (≥1).
- `T_RFC`, 7: auto-refresh-to-next-command cycles (≥1).
- `N_AREF`, 8: number of auto-refresh commands (≥1).
- `T_MRD`, 2: mode-register-set to `init_done` cycles (≥1).

Ports:
- `clk` in 1: SDRAM/controller clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `cfg_mode_reg` in 13: mode-register value. Sampled in the MRS cycle and must be stable during init.
- `reinit` in 1: single-cycle request to rerun the sequence without the power wait. Honoured only when `init_done`=1.
- `sdr_cke` out 1: clock enable.
- `sdr_cs_n`, `sdr_ras_n`, `sdr_cas_n`, `sdr_we_n` out 1 each: command pins.
- `sdr_addr` out 13: address bus (A10 is the precharge-all bit).
- `sdr_ba` out 2: bank address.
- `init_done` out 1: sequence complete. Held high until reset or `reinit`.

## Operation
- All outputs are registered.
- Command encodings `{cs_n,ras_n,cas_n,we_n}`:
  - INHIBIT = 1111
  - NOP = 0111
  - PRE = 0010
  - AREF = 0001
  - MRS = 0000
- Reset values: `sdr_cke`=0, command=INHIBIT, `sdr_addr`=0, `sdr_ba`=0, `init_done`=0. State=S_WAIT and counter=T_PWR_CYC−1.
- S_WAIT: cke=1, NOP, down-count. At 0, go to S_PRE.
- S_PRE: one cycle of PRE with addr=13'h0400 (A10=1) and ba=0. Go to S_TRP with counter=T_RP−1.
- S_TRP: NOP until the counter hits 0, then go to S_AREF and clear the refresh count.
- S_AREF: one cycle of AREF and increment the refresh count. Go to S_TRFC with counter=T_RFC−1.
- S_TRFC: NOP until 0. Then go to S_AREF if refresh count < N_AREF, else S_MRS.
- S_MRS: one cycle of MRS with addr=`cfg_mode_reg` and ba=0. Go to S_TMRD with counter=T_MRD−1.
- S_TMRD: NOP until 0, then go to S_DONE.
- S_DONE: `init_done`=1, command=NOP, addr=0, cke=1. The sequencer's pins are don't-care downstream, but must stay NOP.
- `reinit` in S_DONE: the next cycle has `init_done`=0 and state S_PRE. The sequence then repeats from precharge, with no S_WAIT.
- `reinit` outside S_DONE is ignored.
- `rst` mid-sequence forces reset values immediately. The full sequence including S_WAIT restarts after release.
- Counters saturate at 0 and never wrap. The counter width is `$clog2` of the largest timing parameter plus 1.

## Timing
- Cycle 0 is the first rising edge after `rst` deasserts. Cycles 0 … T_PWR_CYC−1 are NOP with cke=1.
- PRE occurs at cycle P = T_PWR_CYC.
- AREF k (k = 0 … N_AREF−1) occurs at cycle P + T_RP + k·T_RFC.
- MRS occurs at cycle M = P + T_RP + N_AREF·T_RFC.
- `init_done` rises at cycle M + T_MRD. With default parameters that is 10000+2+56+2 = cycle 10060.
- After a `reinit` pulse at cycle R: PRE at R+1 and `init_done` low from R+1. `init_done` rises again at R+1+T_RP+N_AREF·T_RFC+T_MRD.
- Exactly one PRE, N_AREF AREF and one MRS are issued per sequence. Every other cycle before `init_done` is NOP.

## Structure
- Package `sdram_init_pkg`: state enum (S_WAIT, S_PRE, S_TRP, S_AREF, S_TRFC, S_MRS, S_TMRD, S_DONE), 4-bit command constants, `PRE_ALL_ADDR`=13'h0400.
- Optional sub-module `sdram_delay_cnt`: loadable saturating down-counter with a `zero` flag, shared by all wait states.

## Test plan
Unless stated otherwise, benches run with T_PWR_CYC=20, T_RP=2, T_RFC=7, N_AREF=8, T_MRD=2, `cfg_mode_reg`=13'h0033.
- Reset release, no other stimulus:
  - NOP at cycles 0–19, PRE with addr 13'h0400 at cycle 20.
  - AREF at 22, 29, …, 71.
  - MRS with addr 13'h0033 and ba 0 at cycle 78.
  - `init_done` rises at 80 and stays high.
- Reset during AREF #3 (held 3 cycles): all outputs go to reset values asynchronously. After release, PRE comes 20 cycles later and no stray AREF/MRS is issued.
- `reinit` pulse at cycle 100: `init_done`=0 at 101, PRE at 101, first AREF at 103, MRS at 159, `init_done` high at 161.
- `reinit` pulsed at cycle 30 (mid-sequence): ignored, timing identical to the first scenario.
- Defaults (T_PWR_CYC=10000): PRE at 10000, `init_done` rises at 10060. Count exactly 8 AREF and 1 MRS.
- Parameter corner N_AREF=1, T_RP=T_RFC=T_MRD=1: PRE at 20, AREF at 21, MRS at 22, `init_done` at 23.
